fdct_row_butterfly: RTL and testbench
=====================================

FDCT_ROW_BUTTERFLY -- requirements
Module: fdct_row_butterfly

Interface
REQ-001 SHALL have parameter BLOCK_ROWS, default 8, meaning rows per 8x8 block before out_block_end and the row counter wrap.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, a sample is presented on in_data.
REQ-005 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-006 SHALL have port in_data, input, 32, one spatial-domain sample in row order x0..x7.
REQ-007 SHALL have port out_valid, output, 1, u0..u7 hold one completed row result.
REQ-008 SHALL have port out_ready, input, 1, downstream consumes the row this cycle.
REQ-009 SHALL have ports u0..u7, output, 32 each, stage-1 forward butterfly results.
REQ-010 SHALL have port out_row, output, 3, index of the row on u0..u7 within the block.
REQ-011 SHALL have port out_block_end, output, 1, high with out_valid when out_row equals BLOCK_ROWS-1.

Function
REQ-012 SHALL use two states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-013 SHALL accept a sample only when in_valid and in_ready are both high; the sample goes into slot x[cnt], and cnt (3-bit) increments.
REQ-014 SHALL go from COLLECT to HOLD on the cycle the 8th sample (cnt=7) is accepted, with cnt returning to 0.
REQ-015 SHALL register outputs in that same edge, so out_valid rises one cycle after the 8th sample is accepted.
REQ-016 SHALL compute u0=x0+x7, u1=x1+x6, u2=x2+x5, u3=x3+x4, u4=x3-x4, u5=x2-x5, u6=x1-x6, u7=x0-x7.
REQ-017 SHALL compute all arithmetic in 32-bit two's complement, wrapping modulo 2^32 with no saturation or overflow flag.
REQ-018 SHALL keep u0..u7, out_row and out_block_end stable while in HOLD until out_ready is high.
REQ-019 SHALL return to COLLECT on out_valid and out_ready, and increment the row counter, wrapping from BLOCK_ROWS-1 to 0.
REQ-020 SHALL ignore in_valid in HOLD: no sample is captured and cnt does not change.
REQ-021 SHALL treat out_ready as don't-care in COLLECT.
REQ-022 SHALL give a back-to-back row throughput of 9 cycles per row when out_ready is held high (8 accepts + 1 HOLD).

Reset
REQ-023 SHALL on rst, at the next clock edge, enter COLLECT and set cnt=0, row counter=0, out_valid=0, in_ready=1 (after the reset edge), u0..u7=0, out_row=0 and out_block_end=0.
REQ-024 SHALL discard any partially collected row or held result when rst is asserted mid-row or in HOLD; no output is produced for it.
REQ-025 SHALL give rst priority over simultaneous in_valid or out_ready.

Configuration
REQ-026 SHALL, when macro FDCT_LEVEL_SHIFT_EN is defined, capture each sample as zero-extended in_data[7:0] minus 128 (range -128..127, sign-extended to 32 bits) and ignore in_data[31:8].
REQ-027 SHALL, when FDCT_LEVEL_SHIFT_EN is undefined, capture in_data as a full 32-bit two's-complement value unchanged.

Verification
REQ-028 SHALL cover this case (macro undefined): samples 1,2,3,4,5,6,7,8 with out_ready=1 -> one cycle after the 8th accept, u0..u7 = 9,9,9,9,-1,-3,-5,-7 and out_row=0.
REQ-029 SHALL cover this case (FDCT_LEVEL_SHIFT_EN): eight samples of 0x80 -> u0..u7 all 0; then eight samples of 0xFF -> u0..u3=254 and u4..u7=0.
REQ-030 SHALL cover this case: out_ready=0 for 5 cycles in HOLD while in_valid=1 with changing data -> outputs stable, in_ready=0, nothing captured, next row starts at x0.
REQ-031 SHALL cover this case: 8 rows streamed back to back -> out_row steps 0..7, out_block_end only on row 7, the 9th row has out_row=0, and rows come every 9 cycles.
REQ-032 SHALL cover this case: rst after 5 samples, then 8 new samples 10..17 -> first output u0=27 and u7=-7, with no output from the aborted row.
REQ-033 SHALL cover this case (macro undefined): x0=0x7FFFFFFF, x7=1 -> u0=0x80000000 and u7=0x7FFFFFFE (modulo wrap).

Source files
------------

// File: rtl/fdct_row_butterfly.sv
`default_nettype none
// ============================================================================
//  Module   : fdct_row_butterfly
//  Purpose  : First (butterfly) stage of a row-wise 8-point forward DCT.
//             Eight spatial samples x0..x7 are collected one per accepted
//             handshake. On the edge that accepts x7, the sums and
//             differences of mirrored sample pairs are registered onto
//             u0..u7. The result is then held until downstream takes it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BLOCK_ROWS    - rows per block; the row counter wraps after BLOCK_ROWS-1
//  Ports
//    clk           - sole clock, rising edge
//    rst           - synchronous, active-high reset
//    in_valid      - a sample is presented on in_data
//    in_ready      - block accepts a sample this cycle (high while collecting)
//    in_data[31:0] - one spatial sample, presented in row order x0..x7
//    out_valid     - u0..u7 hold a completed row (high while holding)
//    out_ready     - downstream consumes the held row this cycle
//    u0..u7[31:0]  - butterfly results, wrapping 32-bit two's complement
//    out_row[2:0]  - index of the held row within its block
//    out_block_end - held row is the last row of the block
//  Build option
//    FDCT_LEVEL_SHIFT_EN - when defined, each sample is taken as the unsigned
//                          byte in_data[7:0] minus 128, and in_data[31:8] is
//                          ignored. When undefined, in_data is used unchanged.
// ============================================================================
module fdct_row_butterfly #(
   parameter int BLOCK_ROWS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] u0,
   output logic [31:0] u1,
   output logic [31:0] u2,
   output logic [31:0] u3,
   output logic [31:0] u4,
   output logic [31:0] u5,
   output logic [31:0] u6,
   output logic [31:0] u7,
   output logic [2:0]  out_row,
   output logic        out_block_end
);

   typedef enum logic [0:0] {
      S_COLLECT = 1'b0,
      S_HOLD    = 1'b1
   } state_t;

   localparam logic [2:0] c_LAST_ROW  = 3'(BLOCK_ROWS - 1);
   localparam logic [2:0] c_LAST_SLOT = 3'd7;

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [2:0]  r_row;
   // x0..x6 are stored. x7 is never stored because it feeds the butterfly
   // directly on the edge that accepts it.
   logic [31:0] r_x [0:6];

   logic [31:0] w_sample;
   logic        w_accept;
   logic [31:0] w_x   [0:7];
   logic [31:0] w_sum [0:3];
   logic [31:0] w_diff[0:3];

   // ------------------------------------------------------------------------
   // Sample conditioning
   // ------------------------------------------------------------------------
`ifdef FDCT_LEVEL_SHIFT_EN
   // Taking the zero-extended byte minus 128 modulo 2^32 gives the
   // sign-extended value in the range -128..127.
   assign w_sample = {24'd0, in_data[7:0]} - 32'd128;

   // Upper bits are deliberately discarded in this build.
   logic w_unused_hi;
   assign w_unused_hi = ^in_data[31:8];
`else
   assign w_sample = in_data;
`endif

   // in_ready is high exactly in COLLECT, so this is the collect-state accept.
   assign w_accept = in_valid & in_ready;

   // ------------------------------------------------------------------------
   // Butterfly operands: stored x0..x6 plus the sample being accepted as x7
   // ------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < 7; i++) begin
         w_x[i] = r_x[i];
      end
      w_x[7] = w_sample;
   end

   // Mirrored-pair sums and differences. Arithmetic wraps modulo 2^32.
   for (genvar k = 0; k < 4; k++) begin : g_bfly
      assign w_sum[k]  = w_x[k] + w_x[7-k];
      assign w_diff[k] = w_x[k] - w_x[7-k];
   end

   // ------------------------------------------------------------------------
   // Sample storage. These slots need no reset: a fresh row always
   // overwrites x0..x6 before they are used.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      for (int i = 0; i < 7; i++) begin
         if (w_accept && (r_cnt == 3'(i))) begin
            r_x[i] <= w_sample;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM with registered handshake and result outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_COLLECT;
         r_cnt         <= 3'd0;
         r_row         <= 3'd0;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         u0            <= 32'd0;
         u1            <= 32'd0;
         u2            <= 32'd0;
         u3            <= 32'd0;
         u4            <= 32'd0;
         u5            <= 32'd0;
         u6            <= 32'd0;
         u7            <= 32'd0;
         out_row       <= 3'd0;
         out_block_end <= 1'b0;
      end else begin
         case (r_state)
            S_COLLECT: begin
               // out_ready has no effect while collecting.
               if (in_valid) begin
                  // Wraps from 7 back to 0 on the last sample of the row.
                  r_cnt <= r_cnt + 3'd1;
                  if (r_cnt == c_LAST_SLOT) begin
                     r_state       <= S_HOLD;
                     in_ready      <= 1'b0;
                     out_valid     <= 1'b1;
                     u0            <= w_sum[0];
                     u1            <= w_sum[1];
                     u2            <= w_sum[2];
                     u3            <= w_sum[3];
                     u4            <= w_diff[3];
                     u5            <= w_diff[2];
                     u6            <= w_diff[1];
                     u7            <= w_diff[0];
                     out_row       <= r_row;
                     out_block_end <= (r_row == c_LAST_ROW);
                  end
               end
            end

            S_HOLD: begin
               // Results stay frozen and in_valid is ignored until consumed.
               if (out_ready) begin
                  r_state   <= S_COLLECT;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  r_row     <= (r_row == c_LAST_ROW) ? 3'd0 : (r_row + 3'd1);
               end
            end

            default: begin
               r_state   <= S_COLLECT;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fdct_row_butterfly.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fdct_row_butterfly
//  Purpose  : Self-checking bench for fdct_row_butterfly. It applies fixed
//             vectors from a table, then hand-written stall, reset and
//             streaming sequences, and finally randomized rows checked
//             against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fdct_row_butterfly;

   localparam int BR = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] u0, u1, u2, u3, u4, u5, u6, u7;
   logic [2:0]  out_row;
   logic        out_block_end;

   always #5 clk = ~clk;

   fdct_row_butterfly #(.BLOCK_ROWS(BR)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .u0           (u0),
      .u1           (u1),
      .u2           (u2),
      .u3           (u3),
      .u4           (u4),
      .u5           (u5),
      .u6           (u6),
      .u7           (u7),
      .out_row      (out_row),
      .out_block_end(out_block_end)
   );

   logic [31:0] uo [8];
   assign uo[0] = u0;
   assign uo[1] = u1;
   assign uo[2] = u2;
   assign uo[3] = u3;
   assign uo[4] = u4;
   assign uo[5] = u5;
   assign uo[6] = u6;
   assign uo[7] = u7;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Current row's raw samples plus the expected row index.
   logic [31:0] rx [8];
   int          exp_row;
   bit          rand_gaps = 1'b0;

   // Output monitor for the streaming sequence.
   bit          mon_en = 1'b0;
   int          mq_cyc[$];
   logic [2:0]  mq_row[$];
   logic        mq_be[$];
   logic [31:0] mq_u0[$];
   logic [31:0] eq_u0[$];

   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         mq_cyc.push_back(cyc);
         mq_row.push_back(out_row);
         mq_be.push_back(out_block_end);
         mq_u0.push_back(u0);
      end
   end

   typedef struct packed {
      logic [7:0][31:0] x;
      logic [7:0][31:0] u;
   } vec_t;
   vec_t tbl [3];

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   function automatic logic [31:0] shape(input logic [31:0] d);
`ifdef FDCT_LEVEL_SHIFT_EN
      int v;
      v = int'(d[7:0]) - 128;
      return 32'(v);
`else
      return d;
`endif
   endfunction

   function automatic logic [31:0] model_u(input int k);
      logic [31:0] a, b;
      if (k < 4) begin
         a = shape(rx[k]);
         b = shape(rx[7-k]);
         return a + b;
      end
      a = shape(rx[7-k]);
      b = shape(rx[k]);
      return a - b;
   endfunction

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = $urandom;
      tick();
      tick();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      exp_row   = 0;
   endtask

   task automatic push_sample(input logic [31:0] d);
      logic acc;
      int   guard;
      logic save_rdy;
      if (rand_gaps) begin
         save_rdy = out_ready;
         for (int g = 0; g < 3; g++) begin
            if ($urandom_range(0, 2) != 0) break;
            in_valid  = 1'b0;
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            tick();
         end
         out_ready = save_rdy;
      end
      in_valid = 1'b1;
      in_data  = d;
      acc      = 1'b0;
      guard    = 0;
      while (!acc && guard < 20) begin
         acc = in_ready;
         tick();
         guard++;
      end
      in_valid = 1'b0;
      chk("accept", {31'd0, acc}, 32'd1);
   endtask

   task automatic push_row();
      for (int i = 0; i < 8; i++) push_sample(rx[i]);
   endtask

   task automatic check_row_model(input string tag, input int stall);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      for (int k = 0; k < 8; k++)
         chk($sformatf("%s_u%0d", tag, k), uo[k], model_u(k));
      chk({tag, "_row"}, {29'd0, out_row}, exp_row);
      chk({tag, "_bend"}, {31'd0, out_block_end}, (exp_row == BR - 1) ? 32'd1 : 32'd0);
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         tick();
         chk({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
         chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
         for (int k = 0; k < 8; k++)
            chk($sformatf("%s_stall_u%0d", tag, k), uo[k], model_u(k));
         chk({tag, "_stall_row"}, {29'd0, out_row}, exp_row);
      end
      in_valid = 1'b0;
   endtask

   task automatic release_row(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
      exp_row = (exp_row + 1) % BR;
   endtask

   // ------------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------------
   initial begin
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
      exp_row = 0;

      // Table contents.
`ifndef FDCT_LEVEL_SHIFT_EN
      for (int i = 0; i < 8; i++) tbl[0].x[i] = 32'(i + 1);
      tbl[0].u[0] = 32'd9;  tbl[0].u[1] = 32'd9;  tbl[0].u[2] = 32'd9;  tbl[0].u[3] = 32'd9;
      tbl[0].u[4] = -32'd1; tbl[0].u[5] = -32'd3; tbl[0].u[6] = -32'd5; tbl[0].u[7] = -32'd7;
      tbl[1] = '0;
      tbl[1].x[0] = 32'h7FFF_FFFF; tbl[1].x[7] = 32'd1;
      tbl[1].u[0] = 32'h8000_0000; tbl[1].u[7] = 32'h7FFF_FFFE;
      for (int i = 0; i < 8; i++) begin
         tbl[2].x[i] = 32'hFFFF_FFFF;
         tbl[2].u[i] = (i < 4) ? 32'hFFFF_FFFE : 32'd0;
      end
`else
      for (int i = 0; i < 8; i++) begin
         tbl[0].x[i] = 32'h0000_0080;
         tbl[0].u[i] = 32'd0;
         tbl[1].x[i] = 32'h0000_00FF;
         tbl[1].u[i] = (i < 4) ? 32'd254 : 32'd0;
         tbl[2].x[i] = 32'h1234_5600;
         tbl[2].u[i] = (i < 4) ? 32'hFFFF_FF00 : 32'd0;
      end
`endif

      // Reset state.
      do_reset();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_row", {29'd0, out_row}, 32'd0);
      chk("rst_bend", {31'd0, out_block_end}, 32'd0);
      for (int k = 0; k < 8; k++) chk($sformatf("rst_u%0d", k), uo[k], 32'd0);

      // Table-driven vectors. The first row after reset has row index 0.
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 8; i++) rx[i] = tbl[v].x[i];
         push_row();
         chk($sformatf("tbl%0d_valid", v), {31'd0, out_valid}, 32'd1);
         chk($sformatf("tbl%0d_row", v), {29'd0, out_row}, exp_row);
         for (int k = 0; k < 8; k++)
            chk($sformatf("tbl%0d_u%0d", v, k), uo[k], tbl[v].u[k]);
         release_row($sformatf("tbl%0d", v));
      end

      // Stall in HOLD for 5 cycles with changing in_valid data, then a
      // fresh row must start at x0.
      for (int i = 0; i < 8; i++) rx[i] = $urandom;
      push_row();
      check_row_model("hold", 5);
      release_row("hold");
      for (int i = 0; i < 8; i++) rx[i] = $urandom;
      push_row();
      check_row_model("after_hold", 0);
      release_row("after_hold");

      // Reset after five samples discards the partial row.
      for (int i = 0; i < 5; i++) push_sample($urandom);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_row = 0;
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_row", {29'd0, out_row}, 32'd0);
      for (int i = 0; i < 8; i++) rx[i] = 32'(10 + i);
      for (int i = 0; i < 7; i++) push_sample(rx[i]);
      chk("midrst_no_early_valid", {31'd0, out_valid}, 32'd0);
      push_sample(rx[7]);
      check_row_model("midrst", 0);
`ifndef FDCT_LEVEL_SHIFT_EN
      chk("midrst_u0_27", u0, 32'd27);
      chk("midrst_u7_m7", u7, -32'd7);
`endif
      release_row("midrst");

      // Reset while holding drops the held result.
      for (int i = 0; i < 8; i++) rx[i] = $urandom;
      push_row();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_row = 0;
      chk("holdrst_valid", {31'd0, out_valid}, 32'd0);
      chk("holdrst_u0", u0, 32'd0);

      // Nine rows back to back with out_ready held high.
      do_reset();
      mon_en    = 1'b1;
      out_ready = 1'b1;
      for (int r = 0; r < 9; r++) begin
         for (int i = 0; i < 8; i++) rx[i] = $urandom;
         push_row();
         eq_u0.push_back(model_u(0));
      end
      tick();
      tick();
      mon_en    = 1'b0;
      out_ready = 1'b0;
      chk("stream_count", mq_cyc.size(), 32'd9);
      for (int i = 0; i < 9 && i < mq_cyc.size(); i++) begin
         chk($sformatf("stream%0d_row", i), {29'd0, mq_row[i]}, i % BR);
         chk($sformatf("stream%0d_bend", i), {31'd0, mq_be[i]}, (i == BR - 1) ? 32'd1 : 32'd0);
         chk($sformatf("stream%0d_u0", i), mq_u0[i], eq_u0[i]);
         if (i > 0)
            chk($sformatf("stream%0d_period", i), 32'(mq_cyc[i] - mq_cyc[i-1]), 32'd9);
      end

      // Randomized rows with input gaps and output stalls.
      do_reset();
      rand_gaps = 1'b1;
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
               0:       rx[i] = 32'h7FFF_FFFF;
               1:       rx[i] = 32'h8000_0000;
               default: rx[i] = $urandom;
            endcase
         end
         push_row();
         check_row_model($sformatf("rnd%0d", r), $urandom_range(0, 3));
         release_row($sformatf("rnd%0d", r));
      end
      rand_gaps = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
